// File: rtl/ysyx_22050612_pkg.sv
// Shared decode definitions for the ysyx_22050612 core: op codes, immediate
// formats, RISC-V encoding constants and the format-selection helper.
package ysyx_22050612_pkg;

  typedef enum logic [5:0] {
    OP_NONE    = 6'd0,
    OP_ILLEGAL = 6'd1,
    OP_LUI     = 6'd2,
    OP_AUIPC   = 6'd3,
    OP_JAL     = 6'd4,
    OP_JALR    = 6'd5,
    OP_BEQ     = 6'd6,
    OP_BNE     = 6'd7,
    OP_LW      = 6'd8,
    OP_LD      = 6'd9,
    OP_SD      = 6'd10,
    OP_ADDI    = 6'd11,
    OP_SLTIU   = 6'd12,
    OP_ADDIW   = 6'd13,
    OP_SRAI    = 6'd14,
    OP_ADD     = 6'd15,
    OP_SUB     = 6'd16,
    OP_ADDW    = 6'd17,
    OP_EBREAK  = 6'd18
  } op_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [2:0] F3_JALR  = 3'b000;
  localparam logic [2:0] F3_BEQ   = 3'b000;
  localparam logic [2:0] F3_BNE   = 3'b001;
  localparam logic [2:0] F3_LW    = 3'b010;
  localparam logic [2:0] F3_LD    = 3'b011;
  localparam logic [2:0] F3_SD    = 3'b011;
  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] F3_SRAI  = 3'b101;
  localparam logic [2:0] F3_ADD   = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  // Upper six bits of an RV64 shift-immediate; inst[25] is shamt[5].
  localparam logic [5:0] F6_SRA  = 6'b010000;

  localparam logic [31:0] INST_EBREAK = 32'h00100073;

  function automatic imm_fmt_e imm_fmt_of(input op_e op);
    case (op)
      OP_JALR, OP_LW, OP_LD, OP_ADDI,
      OP_SLTIU, OP_ADDIW, OP_SRAI:  imm_fmt_of = IMM_I;
      OP_SD:                        imm_fmt_of = IMM_S;
      OP_BEQ, OP_BNE:               imm_fmt_of = IMM_B;
      OP_LUI, OP_AUIPC:             imm_fmt_of = IMM_U;
      OP_JAL:                       imm_fmt_of = IMM_J;
      default:                      imm_fmt_of = IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050612_id_decode.sv
// Combinational instruction decoder: maps one instruction word to an op code,
// its sign-extended immediate and the illegal/ebreak flags.
module ysyx_22050612_id_decode
  import ysyx_22050612_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     inst,
  output op_e             op,
  output logic [XLEN-1:0] imm,
  output logic            illegal,
  output logic            ebreak
);

  localparam bit IS64 = (XLEN == 64);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm32;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  always_comb begin
    op = OP_ILLEGAL;
    case (opcode)
      OPC_LUI:   op = OP_LUI;
      OPC_AUIPC: op = OP_AUIPC;
      OPC_JAL:   op = OP_JAL;
      OPC_JALR:  if (funct3 == F3_JALR) op = OP_JALR;
      OPC_BRANCH: begin
        if (funct3 == F3_BEQ)      op = OP_BEQ;
        else if (funct3 == F3_BNE) op = OP_BNE;
      end
      OPC_LOAD: begin
        if (funct3 == F3_LW)              op = OP_LW;
        else if (IS64 && funct3 == F3_LD) op = OP_LD;
      end
      OPC_STORE: if (IS64 && funct3 == F3_SD) op = OP_SD;
      OPC_OPIMM: begin
        case (funct3)
          F3_ADDI:  op = OP_ADDI;
          F3_SLTIU: op = OP_SLTIU;
          F3_SRAI: begin
            // RV32 has a 5-bit shamt, so inst[25] set is not a valid shift.
            if (inst[31:26] == F6_SRA && (IS64 || !inst[25])) op = OP_SRAI;
          end
          default: ;
        endcase
      end
      OPC_OPIMM32: if (IS64 && funct3 == F3_ADDI) op = OP_ADDIW;
      OPC_OP: begin
        if (funct3 == F3_ADD && funct7 == F7_BASE)     op = OP_ADD;
        else if (funct3 == F3_ADD && funct7 == F7_ALT) op = OP_SUB;
      end
      OPC_OP32: if (IS64 && funct3 == F3_ADD && funct7 == F7_BASE) op = OP_ADDW;
      OPC_SYSTEM: if (inst == INST_EBREAK) op = OP_EBREAK;
      default: ;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (imm_fmt_of(op))
      IMM_I: imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U: imm32 = {inst[31:12], 12'b0};
      IMM_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm     = XLEN'($signed(imm32));
  assign illegal = (op == OP_ILLEGAL);
  assign ebreak  = (inst == INST_EBREAK);

endmodule

// File: rtl/ysyx_22050612_id_stage.sv
// Registered decode stage between IFU and EXU with a two-entry skid buffer:
// M drives the outputs, S absorbs one extra accept under back-pressure.
module ysyx_22050612_id_stage
  import ysyx_22050612_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output op_e             out_op,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [5:0]      out_shamt,
  output logic            out_illegal,
  output logic            out_ebreak
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    op_e             op;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [5:0]      shamt;
    logic            illegal;
    logic            ebreak;
  } entry_t;

  op_e             dec_op;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic            dec_ebreak;
  entry_t          dec_entry;

  entry_t m_q, m_d, s_q, s_d;
  logic   m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic   accept, handoff;

  ysyx_22050612_id_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .inst    (in_inst),
    .op      (dec_op),
    .imm     (dec_imm),
    .illegal (dec_illegal),
    .ebreak  (dec_ebreak)
  );

  always_comb begin
    dec_entry         = '0;
    dec_entry.pc      = in_pc;
    dec_entry.op      = dec_op;
    dec_entry.imm     = dec_imm;
    dec_entry.rd      = in_inst[11:7];
    dec_entry.rs1     = in_inst[19:15];
    dec_entry.rs2     = in_inst[24:20];
    dec_entry.shamt   = {(XLEN == 64) ? in_inst[25] : 1'b0, in_inst[24:20]};
    dec_entry.illegal = dec_illegal;
    dec_entry.ebreak  = dec_ebreak;
  end

  // in_ready comes straight from the S flag, so it never sees out_ready.
  assign in_ready = ~s_valid_q;
  assign accept   = in_valid & in_ready;
  assign handoff  = m_valid_q & out_ready;

  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      if (handoff) begin
        if (s_valid_q) begin
          m_d       = s_q;
          s_valid_d = 1'b0;
        end else begin
          m_valid_d = 1'b0;
        end
      end
      // S full blocks accept, so a refill from S and a new accept never collide.
      if (accept) begin
        if (!m_valid_q || handoff) begin
          m_d       = dec_entry;
          m_valid_d = 1'b1;
        end else begin
          s_d       = dec_entry;
          s_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q       <= '0;
      s_q       <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign out_valid   = m_valid_q;
  assign out_pc      = m_q.pc;
  assign out_op      = m_q.op;
  assign out_imm     = m_q.imm;
  assign out_rd      = m_q.rd;
  assign out_rs1     = m_q.rs1;
  assign out_rs2     = m_q.rs2;
  assign out_shamt   = m_q.shamt;
  assign out_illegal = m_q.illegal;
  assign out_ebreak  = m_q.ebreak;

endmodule

// File: tb/tb_ysyx_22050612_id_stage.sv
// Directed bench for the decode stage: one RV64 and one RV32 instance share
// stimulus; expected values are hand-computed from the instruction encodings.
module tb_ysyx_22050612_id_stage;
  import ysyx_22050612_pkg::*;

  logic        clk, rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic [31:0] in_pc32;

  logic        in_ready, out_valid, out_illegal, out_ebreak;
  logic [63:0] out_pc, out_imm;
  op_e         out_op;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [5:0]  out_shamt;

  logic        in_ready32, out_valid32, out_illegal32, out_ebreak32;
  logic [31:0] out_pc32, out_imm32;
  op_e         out_op32;
  logic [4:0]  out_rd32, out_rs132, out_rs232;
  logic [5:0]  out_shamt32;

  int checks   = 0;
  int failures = 0;

  assign in_pc32 = in_pc[31:0];

  ysyx_22050612_id_stage #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
    .out_imm(out_imm), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_shamt(out_shamt), .out_illegal(out_illegal), .out_ebreak(out_ebreak)
  );

  ysyx_22050612_id_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst), .in_pc(in_pc32),
    .out_valid(out_valid32), .out_ready(out_ready), .out_pc(out_pc32), .out_op(out_op32),
    .out_imm(out_imm32), .out_rd(out_rd32), .out_rs1(out_rs132), .out_rs2(out_rs232),
    .out_shamt(out_shamt32), .out_illegal(out_illegal32), .out_ebreak(out_ebreak32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] inst, input logic [63:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_op", out_op, OP_NONE);
    check("rst_out_imm", out_imm, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_illegal", out_illegal, 0);
    check("rst32_out_valid", out_valid32, 0);
    rst = 1'b0;

    // Decode vectors, streamed back to back with out_ready high.
    out_ready = 1'b1;
    send(32'hFFF00093, 64'h100);
    check("addi_valid", out_valid, 1);
    check("addi_op", out_op, OP_ADDI);
    check("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_rd", out_rd, 1);
    check("addi_rs1", out_rs1, 0);
    check("addi_illegal", out_illegal, 0);
    check("addi_pc", out_pc, 64'h100);

    send(32'hFE101EE3, 64'h104);
    check("bne_op", out_op, OP_BNE);
    check("bne_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    check("bne_rs2", out_rs2, 1);
    check("bne_rs1", out_rs1, 0);
    check("bne_pc", out_pc, 64'h104);

    send(32'h00100073, 64'h108);
    check("ebreak_flag", out_ebreak, 1);
    check("ebreak_op", out_op, OP_EBREAK);
    check("ebreak_illegal", out_illegal, 0);

    send(32'hFFFFFFFF, 64'h10C);
    check("ones_illegal", out_illegal, 1);
    check("ones_op", out_op, OP_ILLEGAL);
    check("ones_imm", out_imm, 0);
    check("ones_ebreak", out_ebreak, 0);

    send(32'h800000B7, 64'h110);
    check("lui_op", out_op, OP_LUI);
    check("lui_imm", out_imm, 64'hFFFF_FFFF_8000_0000);
    check("lui32_imm", out_imm32, 32'h8000_0000);

    send(32'h0000B083, 64'h114);
    check("ld_op", out_op, OP_LD);
    check("ld_rd", out_rd, 1);
    check("ld_rs1", out_rs1, 1);
    check("ld32_illegal", out_illegal32, 1);
    check("ld32_op", out_op32, OP_ILLEGAL);

    send(32'h4200D093, 64'h118);
    check("srai_op", out_op, OP_SRAI);
    check("srai_shamt", out_shamt, 32);
    check("srai_imm", out_imm, 64'h420);
    check("srai32_illegal", out_illegal32, 1);
    check("srai32_shamt", out_shamt32, 0);

    tick();
    check("drain_valid", out_valid, 0);

    // Back-pressure: three cycles of out_ready low while streaming 0x0/0x4/0x8.
    out_ready = 1'b0;
    send(32'hFFF00093, 64'h0);
    check("bp_in_ready_1", in_ready, 1);
    check("bp_pc_m", out_pc, 0);
    send(32'hFFF00093, 64'h4);
    check("bp_in_ready_2", in_ready, 0);
    check("bp_pc_hold", out_pc, 0);
    in_valid = 1'b1; in_pc = 64'h8;
    tick();
    check("bp_in_ready_3", in_ready, 0);
    check("bp_valid_hold", out_valid, 1);
    check("bp_pc_hold2", out_pc, 0);
    out_ready = 1'b1;
    tick();
    check("bp_rel_pc4", out_pc, 64'h4);
    check("bp_rel_valid4", out_valid, 1);
    check("bp_rel_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_rel_pc8", out_pc, 64'h8);
    check("bp_rel_valid8", out_valid, 1);
    tick();
    check("bp_empty", out_valid, 0);

    // Flush with both entries full and an input offered on the same edge.
    out_ready = 1'b0;
    send(32'hFFF00093, 64'h10);
    send(32'hFFF00093, 64'h14);
    check("fl_full", in_ready, 0);
    flush = 1'b1; in_valid = 1'b1; in_pc = 64'h18;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    check("fl_quiet_1", out_valid, 0);
    tick();
    check("fl_quiet_2", out_valid, 0);

    // Asynchronous reset mid-cycle with M holding an instruction.
    out_ready = 1'b0;
    send(32'hFFF00093, 64'h20);
    check("ar_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_out_valid32", out_valid32, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_out_pc", out_pc, 0);
    check("ar_out_op", out_op, OP_NONE);
    rst = 1'b0;
    tick();
    check("ar_after_valid", out_valid, 0);
    send(32'h00100073, 64'h24);
    check("ar_resume_op", out_op, OP_EBREAK);
    check("ar_resume_pc", out_pc, 64'h24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
